// File: rtl/par2ser_pkg.sv
// rtl/par2ser_pkg.sv - shared types and constants for the parallel-to-serial converter
// Purpose: FSM state encoding and the K28.5 comma symbols used as idle filler.
// Ports: none (package).
package par2ser_pkg;

  typedef enum logic {
    S_START = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

endpackage

// File: rtl/p2s_hold_reg.sv
// rtl/p2s_hold_reg.sv - one-entry holding buffer in front of the shifter
// Purpose: stores one symbol accepted while the shifter is busy.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the buffer)
//   push, din    write din into the buffer
//   pop          release the stored entry to the shifter
//   dout, full   stored entry and its occupancy flag
// push and pop together replace the entry and leave the buffer full.
module p2s_hold_reg
  import par2ser_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (push) begin
      data_d = din;
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/par2ser_gen.sv
// rtl/par2ser_gen.sv - gapless parallel-to-serial converter with idle insertion
// Purpose: takes WIDTH-bit symbols over valid/ready and shifts them out one bit
// per clock; inserts IDLE_WORD whenever no symbol is ready at a word boundary.
// Ports:
//   CLK, RESET   clock, synchronous active-high reset
//   DATA_IN      parallel symbol, qualified by VALID_IN
//   READY_OUT    symbol is accepted on an edge where VALID_IN & READY_OUT
//   SERIAL_OUT   serial bit stream
//   SYM_START    first bit of every emitted word
//   IDLE_OUT     current word is the inserted idle symbol
module par2ser_gen
  import par2ser_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(K28_5_RDN)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic             SERIAL_OUT,
  output logic             SYM_START,
  output logic             IDLE_OUT
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic             idle_q, idle_d;

  logic             load_now;
  logic             accept;
  logic             hold_push;
  logic             hold_pop;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;

  assign load_now  = (state_q == S_START) || ((state_q == S_RUN) && (bit_cnt_q == LAST_CNT));
  assign READY_OUT = ~RESET & (~hold_full | load_now);
  assign accept    = VALID_IN & READY_OUT;

  // An accept goes straight to the shifter only when loading with an empty
  // hold register; otherwise it is parked in the hold register.
  assign hold_pop  = load_now & hold_full;
  assign hold_push = accept & (hold_full | ~load_now);

  p2s_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk  (CLK),
    .rst  (RESET),
    .push (hold_push),
    .pop  (hold_pop),
    .din  (DATA_IN),
    .dout (hold_data),
    .full (hold_full)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shifter_d = shifter_q;
    idle_d    = idle_q;
    if (load_now) begin
      state_d   = S_RUN;
      bit_cnt_d = '0;
      if (hold_full) begin
        shifter_d = hold_data;
        idle_d    = 1'b0;
      end else if (accept) begin
        shifter_d = DATA_IN;
        idle_d    = 1'b0;
      end else begin
        shifter_d = IDLE_WORD;
        idle_d    = 1'b1;
      end
    end else begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (MSB_FIRST) begin
        shifter_d = {shifter_q[WIDTH-2:0], 1'b0};
      end else begin
        shifter_d = {1'b0, shifter_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_START;
      bit_cnt_q <= '0;
      shifter_q <= '0;
      idle_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shifter_q <= shifter_d;
      idle_q    <= idle_d;
    end
  end

  assign SERIAL_OUT = MSB_FIRST ? shifter_q[WIDTH-1] : shifter_q[0];
  assign SYM_START  = (state_q == S_RUN) && (bit_cnt_q == '0);
  assign IDLE_OUT   = idle_q;

endmodule

// File: tb/tb_par2ser_gen.sv
// tb/tb_par2ser_gen.sv - scoreboard bench for par2ser_gen (MSB-first and LSB-first instances)
module tb_par2ser_gen;

  typedef struct {
    logic ser;
    logic sym;
    logic idl;
    logic rdy;
  } exp_t;

  localparam logic [9:0] IDLE_MSB = 10'b0011111010;
  localparam logic [9:0] IDLE_LSB = 10'b0101111100;

  logic       clk;
  logic       rst_m, valid_m, ready_m, ser_m, sym_m, idl_m;
  logic [9:0] data_m;
  logic       rst_l, valid_l, ready_l, ser_l, sym_l, idl_l;
  logic [9:0] data_l;

  exp_t  q_m[$];
  exp_t  q_l[$];
  int    vectors;
  int    miscompares;
  string test_name;

  par2ser_gen #(.WIDTH(10), .MSB_FIRST(1'b1), .IDLE_WORD(10'b0011111010)) dut_m (
    .CLK(clk), .RESET(rst_m), .DATA_IN(data_m), .VALID_IN(valid_m),
    .READY_OUT(ready_m), .SERIAL_OUT(ser_m), .SYM_START(sym_m), .IDLE_OUT(idl_m)
  );

  par2ser_gen #(.WIDTH(10), .MSB_FIRST(1'b0), .IDLE_WORD(10'b0011111010)) dut_l (
    .CLK(clk), .RESET(rst_l), .DATA_IN(data_l), .VALID_IN(valid_l),
    .READY_OUT(ready_l), .SERIAL_OUT(ser_l), .SYM_START(sym_l), .IDLE_OUT(idl_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q_m.size() > 0) begin
      exp_t e;
      e = q_m.pop_front();
      vectors++;
      if (ser_m !== e.ser || sym_m !== e.sym || idl_m !== e.idl || ready_m !== e.rdy) begin
        miscompares++;
        $display("FAIL %s msb t=%0t ser/sym/idle/ready got %b%b%b%b want %b%b%b%b", test_name, $time,
                 ser_m, sym_m, idl_m, ready_m, e.ser, e.sym, e.idl, e.rdy);
      end
    end
  end

  always @(negedge clk) begin
    if (q_l.size() > 0) begin
      exp_t e;
      e = q_l.pop_front();
      vectors++;
      if (ser_l !== e.ser || sym_l !== e.sym || idl_l !== e.idl || ready_l !== e.rdy) begin
        miscompares++;
        $display("FAIL %s lsb t=%0t ser/sym/idle/ready got %b%b%b%b want %b%b%b%b", test_name, $time,
                 ser_l, sym_l, idl_l, ready_l, e.ser, e.sym, e.idl, e.rdy);
      end
    end
  end

  task automatic push_e(input bit lsb, input logic ser, input logic sym, input logic idl, input logic rdy);
    exp_t e;
    e.ser = ser;
    e.sym = sym;
    e.idl = idl;
    e.rdy = rdy;
    if (lsb) q_l.push_back(e);
    else     q_m.push_back(e);
  endtask

  // seq[9] is the first bit on the wire; mask[i] is READY_OUT at bit_cnt i.
  task automatic push_word(input bit lsb, input logic [9:0] seq, input logic idl,
                           input logic [9:0] mask, input int n);
    for (int i = 0; i < n; i++) push_e(lsb, seq[9-i], (i == 0), idl, mask[i]);
  endtask

  // Leaves the bench 1 time unit into the S_START cycle with reset released.
  task automatic do_reset(input bit lsb);
    @(posedge clk); #1;
    if (lsb) begin rst_l = 1'b1; valid_l = 1'b0; end
    else     begin rst_m = 1'b1; valid_m = 1'b0; end
    @(posedge clk); #1;
    push_e(lsb, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    if (lsb) rst_l = 1'b0;
    else     rst_m = 1'b0;
    push_e(lsb, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (q_m.size() > 0 || q_l.size() > 0); i++) @(posedge clk);
    if (q_m.size() > 0 || q_l.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s drain timeout left msb=%0d lsb=%0d want 0", test_name, q_m.size(), q_l.size());
      q_m.delete();
      q_l.delete();
    end
  endtask

  initial begin
    logic [9:0] words[3];
    int         idx;
    logic       acc;
    vectors = 0;
    miscompares = 0;
    rst_m = 1'b1; valid_m = 1'b0; data_m = '0;
    rst_l = 1'b1; valid_l = 1'b0; data_l = '0;

    test_name = "idle_only";
    do_reset(1'b0);
    for (int w = 0; w < 3; w++) push_word(1'b0, IDLE_MSB, 1'b1, 10'h3FF, 10);
    wait_drain();

    test_name = "bypass_start";
    do_reset(1'b0);
    valid_m = 1'b1; data_m = 10'b0010010101;
    push_word(1'b0, 10'b0010010101, 1'b0, 10'h3FF, 10);
    push_word(1'b0, IDLE_MSB, 1'b1, 10'h3FF, 10);
    @(posedge clk); #1 valid_m = 1'b0;
    wait_drain();

    test_name = "stream3";
    words[0] = 10'b0010101000;
    words[1] = 10'b1100111001;
    words[2] = 10'b0101001111;
    do_reset(1'b0);
    push_word(1'b0, words[0], 1'b0, 10'b1000000001, 10);
    push_word(1'b0, words[1], 1'b0, 10'b1000000000, 10);
    push_word(1'b0, words[2], 1'b0, 10'h3FF, 10);
    push_word(1'b0, IDLE_MSB, 1'b1, 10'h3FF, 10);
    valid_m = 1'b1; data_m = words[0];
    idx = 0;
    for (int c = 0; c < 100 && idx < 3; c++) begin
      @(negedge clk);
      acc = ready_m;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx == 3) valid_m = 1'b0;
        else          data_m = words[idx];
      end
    end
    valid_m = 1'b0;
    wait_drain();

    test_name = "lsb_first";
    do_reset(1'b1);
    valid_l = 1'b1; data_l = 10'b1010100110;
    push_word(1'b1, 10'b0110010101, 1'b0, 10'h3FF, 10);
    push_word(1'b1, IDLE_LSB, 1'b1, 10'h3FF, 10);
    @(posedge clk); #1 valid_l = 1'b0;
    wait_drain();
    @(posedge clk); #1 rst_l = 1'b1;

    test_name = "mid_idle_accept";
    do_reset(1'b0);
    push_word(1'b0, IDLE_MSB, 1'b1, 10'b1000011111, 10);
    push_word(1'b0, 10'b1100111001, 1'b0, 10'h3FF, 10);
    push_word(1'b0, IDLE_MSB, 1'b1, 10'h3FF, 10);
    repeat (5) @(posedge clk);
    #1 valid_m = 1'b1; data_m = 10'b1100111001;
    repeat (5) @(posedge clk);
    #1 valid_m = 1'b0;
    wait_drain();

    test_name = "reset_mid_word";
    do_reset(1'b0);
    push_word(1'b0, IDLE_MSB, 1'b1, 10'b0000000111, 5);
    push_e(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    push_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_word(1'b0, IDLE_MSB, 1'b1, 10'h3FF, 10);
    repeat (3) @(posedge clk);
    #1 valid_m = 1'b1; data_m = 10'b0101001111;
    @(posedge clk);
    #1 valid_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_m = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_m = 1'b0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/par2ser_gen.md
# par2ser_gen

Parametrised parallel-to-serial converter for the lane transmit path: accepts WIDTH-bit symbols over a valid/ready handshake and emits them one bit per clock, back-to-back with no gaps. A one-entry holding register double-buffers input so a new symbol can be accepted while the current one shifts. When no symbol is available at a word boundary, a programmable idle/comma word is inserted so the serial stream never stalls.

## Interface
- WIDTH, 10, symbol width in bits (≥2).
- MSB_FIRST, 1, 1: bit WIDTH-1 first; 0: bit 0 first.
- IDLE_WORD, 10'b0011111010 (K28.5 RD-), filler symbol inserted when no data is available; width WIDTH.
- CLK  input  1  clock, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- DATA_IN  input  WIDTH  parallel symbol.
- VALID_IN  input  1  DATA_IN valid.
- READY_OUT  output  1  block can accept DATA_IN this cycle.
- SERIAL_OUT  output  1  serial bit stream.
- SYM_START  output  1  high during the first bit of every emitted word.
- IDLE_OUT  output  1  high for all WIDTH bits of an inserted IDLE_WORD.

## Operation
- Accept = VALID_IN & READY_OUT, evaluated at the rising edge.
- FSM: S_START (one cycle after reset, acts as a load cycle) -> S_RUN (permanent until RESET).
- load_now = (state==S_START) | (state==S_RUN & bit_cnt==WIDTH-1).
- READY_OUT = ~RESET & (~hold_full | load_now) (combinational from registers and RESET).
- At a load edge, shifter source priority: hold register if full; else DATA_IN if accepted (bypass); else IDLE_WORD with IDLE_OUT=1.
- Hold full at load and new accept in same cycle: hold -> shifter, DATA_IN -> hold; hold stays full.
- Accept at a non-load edge: DATA_IN -> hold, hold_full=1 (only possible when hold empty).
- Non-load edge in S_RUN: shifter shifts one position toward the output end; bit_cnt increments.
- bit_cnt: 0..WIDTH-1, wraps to 0 at each load; width $clog2(WIDTH).
- SERIAL_OUT = shifter[WIDTH-1] if MSB_FIRST, else shifter[0].
- SYM_START = (state==S_RUN & bit_cnt==0), registered alongside bit_cnt.
- IDLE_OUT registered at load, held constant for the whole word.

## Timing
- Reset values (edge with RESET=1): state=S_START, shifter=0, bit_cnt=0, hold_full=0, IDLE_OUT=0; thus SERIAL_OUT=0, SYM_START=0; READY_OUT=0 while RESET high.
- First cycle after reset release: S_START, READY_OUT=1, SERIAL_OUT=0.
- Load at end of S_START; first bit of first word on SERIAL_OUT the following cycle with SYM_START=1.
- Word period exactly WIDTH cycles; no bubbles between words.
- Latency, bypass path: accept on load edge -> first bit visible next cycle.
- Latency, hold path: accept mid-word -> first bit one cycle after the next load edge (≤ WIDTH cycles).
- Throughput: at most one accept per WIDTH cycles sustained; READY_OUT low only when hold full and not at load_now.
- RESET mid-word: current word and hold contents discarded, no partial completion; restart via S_START.
- VALID_IN with READY_OUT=0: not accepted; sender must hold data (no drop, no overwrite of hold).

## Structure
- Package par2ser_pkg: state encoding (S_START, S_RUN), K28_5_RDN = 10'b0011111010, K28_5_RDP = 10'b1100000101.
- One sub-module is natural: p2s_hold_reg (one-entry buffer: data, full flag, push/pop, simultaneous push+pop).
- Top contains FSM, bit counter, shifter, source mux.

## Test plan
- Reset then VALID_IN=0 forever (WIDTH=10, MSB_FIRST=1) -> repeating 0,0,1,1,1,1,1,0,1,0 every 10 cycles, IDLE_OUT=1, SYM_START each 10th cycle.
- DATA_IN=10'b0010010101 held valid from reset release -> accepted in S_START, serial 0,0,1,0,0,1,0,1,0,1, IDLE_OUT=0.
- Stream 10'b0010101000, 10'b1100111001, 10'b0101001111 with VALID_IN always high -> three words back-to-back, no idle between, READY_OUT high only at each load cycle once hold fills.
- MSB_FIRST=0, DATA_IN=10'b1010100110 -> serial 0,1,1,0,0,1,0,1,0,1.
- Accept 10'b1100111001 at bit_cnt=4 of an idle word -> idle completes, word follows immediately at next load; VALID_IN held with READY_OUT=0 not consumed twice.
- RESET asserted at bit_cnt=5 with hold full -> SERIAL_OUT=0, READY_OUT=0; after release, held word absent, stream restarts with IDLE_WORD.
